vz_ram_writer: RTL and testbench
================================

Name: vz_ram_writer

Overview:
- Downstream stage of the VZ snapshot loader. Consumes the loader's level-style write bus (address, data, write) and turns it into single-cycle writes on the system RAM port.
- Loader writes are buffered in a small FIFO. They drain only in cycles the CPU has not claimed, and only if the address falls inside the RAM window.
- The block asks for a CPU hold when the FIFO nears full. It flags overflow and counts dropped writes.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- RAM_LO, 16'h7800, lowest writable address (inclusive).
- RAM_HI, 16'hF7FF, highest writable address (inclusive).
- HOLD_LEVEL, 6, FIFO occupancy at or above which cpu_hold asserts; must be less than DEPTH.

Ports:
- I_CLK  in  1  system clock; only clock in the block.
- I_RST_N  in  1  asynchronous, active-low reset.
- ld_wr  in  1  loader write-enable; a level that may stay high across many writes.
- ld_addr  in  16  loader target address.
- ld_data  in  8  loader data byte.
- clr_flags  in  1  synchronous clear of overflow and drop_cnt.
- cpu_slot  in  1  high in cycle t means the CPU owns RAM in cycle t+1.
- ram_addr  out  16  RAM write address.
- ram_din  out  8  RAM write data.
- ram_we  out  1  RAM write strobe, one cycle per write.
- cpu_hold  out  1  asks the CPU wrapper to stall.
- busy  out  1  load traffic still pending.
- overflow  out  1  sticky: a write was lost because the FIFO was full.
- drop_cnt  out  8  saturating count of out-of-window writes.

Behaviour:
- Reset (I_RST_N low, asynchronous):
  - FIFO emptied; FSM goes to IDLE.
  - ram_addr=0, ram_din=0, ram_we=0, cpu_hold=0, busy=0, overflow=0, drop_cnt=0.
  - Internal prev_wr=0, last_addr=0, last_data=0.
  - Reset mid-drain discards every pending entry; no partial strobe.
- Capture, evaluated at each rising edge:
  - accept = ld_wr && (!prev_wr || ld_addr!=last_addr || ld_data!=last_data).
  - prev_wr <= ld_wr every cycle. last_addr/last_data update only on accept.
  - ld_wr low then high again re-accepts an identical pair.
  - An unchanged pair held with ld_wr high is accepted once only.
- Window check on accept:
  - RAM_LO <= ld_addr <= RAM_HI: push to FIFO.
  - Otherwise: entry discarded; drop_cnt increments, saturating at 255.
- FIFO:
  - Push when full with no pop in the same cycle: entry lost, overflow <= 1.
  - Push and pop in the same cycle when full: both happen, no overflow, occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter has DEPTH+1 legal values (0..DEPTH).
- Drain FSM, two states:
  - IDLE: if FIFO not empty and cpu_slot==0, pop the head; at the same edge register ram_addr/ram_din and set ram_we=1; go to WRITE.
  - WRITE: ram_we=1 for exactly this one cycle.
    - If FIFO is non-empty after the pop (accounting for same-cycle push) and cpu_slot==0, pop the next entry and stay in WRITE (back-to-back strobes, one per cycle).
    - Else ram_we <= 0 and go to IDLE.
  - cpu_slot==1 at an edge always forces ram_we low for the next cycle. The pending entry stays in the FIFO.
- Latency: ld input accepted at edge k appears with ram_we=1 in cycle k+1..k+2 (second edge) when FIFO was empty and cpu_slot=0.
- Ordering: writes leave in acceptance order; no combining or reordering.
- ram_addr/ram_din hold their last value while ram_we=0.
- cpu_hold: registered; value = occupancy after this edge >= HOLD_LEVEL.
- busy: registered; value = ld_wr || FIFO non-empty || ram_we.
- clr_flags:
  - Clears overflow and drop_cnt at the edge.
  - A same-cycle overflow or drop event wins: overflow=1 or drop_cnt=1 respectively.

Test Plan:
- Window write, FIFO empty: ld_wr=1, 16'h7AE9/8'h3C held 5 cycles, cpu_slot=0 → exactly one ram_we pulse, two edges after the first accept, with 7AE9/3C.
- Burst with contention: 4 distinct writes 7800..7803 on consecutive cycles, cpu_slot=1 for 3 cycles then 0 → no strobes during the hold, then 4 back-to-back strobes in order 7800..7803.
- Window and drop: write to 16'h0010, then to 16'hF800 → no ram_we; drop_cnt=2. Then clr_flags → drop_cnt=0.
- Overflow and hold: DEPTH=8, cpu_slot=1 held, 9 distinct writes → cpu_hold=1 after the 6th; overflow=1 after the 9th. Release cpu_slot → 8 strobes; the 9th write never appears.
- Re-accept and same-cycle full: ld_wr pulsed twice with the same pair 78A4/12 → two strobes. Fill FIFO to 8 and push with cpu_slot=0 → no overflow; occupancy stays 8.
- Reset mid-drain: I_RST_N low with 5 entries pending → ram_we=0 immediately; after release, busy=0 and no strobes.

Source files
------------

// File: rtl/vz_ram_writer.sv
// ---------------------------------------------------------------------------
// vz_ram_writer
// Downstream stage of the VZ snapshot loader. Captures the loader's
// level-style write bus, buffers accepted in-window writes in a small FIFO and
// drains them as single-cycle RAM write strobes in cycles the CPU has not
// claimed.
//
// Ports:
//   I_CLK, I_RST_N       clock, asynchronous active-low reset
//   ld_wr/ld_addr/ld_data loader write bus (ld_wr is a level)
//   clr_flags            synchronous clear of overflow and drop_cnt
//   cpu_slot             high in cycle t: CPU owns RAM in cycle t+1
//   ram_addr/ram_din/ram_we  RAM write port (one strobe per write)
//   cpu_hold             stall request while the FIFO is nearly full
//   busy                 load traffic still pending
//   overflow             sticky: a write was lost on a full FIFO
//   drop_cnt             saturating count of out-of-window writes
// ---------------------------------------------------------------------------
module vz_ram_writer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [15:0] RAM_LO     = 16'h7800,
  parameter logic [15:0] RAM_HI     = 16'hF7FF,
  parameter int unsigned HOLD_LEVEL = 6
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        clr_flags,
  input  logic        cpu_slot,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  // FIFO storage (no reset needed: pointers and count define validity)
  entry_t mem_q [DEPTH];

  state_e        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          prev_wr_q,  prev_wr_d;
  logic [15:0]   last_addr_q, last_addr_d;
  logic [7:0]    last_data_q, last_data_d;
  logic [15:0]   ram_addr_q, ram_addr_d;
  logic [7:0]    ram_din_q,  ram_din_d;
  logic          ram_we_q,   ram_we_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          busy_q,     busy_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic   accept;
  logic   in_window;
  logic   push_req;
  logic   push;
  logic   pop;
  logic   drop_evt;
  logic   ovf_evt;
  logic   fifo_empty;
  logic   fifo_full;
  entry_t head;

  // Capture, FIFO bookkeeping, drain FSM and flag next-state logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    prev_wr_d   = ld_wr;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    // A held, unchanged pair is one write; a new pair or a fresh rise is another
    accept    = ld_wr && (!prev_wr_q || (ld_addr != last_addr_q) ||
                          (ld_data != last_data_q));
    in_window = (ld_addr >= RAM_LO) && (ld_addr <= RAM_HI);
    push_req  = accept && in_window;
    drop_evt  = accept && !in_window;

    fifo_empty = (count_q == CW'(0));
    fifo_full  = (count_q == CW'(DEPTH));
    head       = mem_q[rd_ptr_q];

    // The CPU's claim on the next cycle blocks the pop; the entry stays queued
    pop     = !fifo_empty && !cpu_slot;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    push    = push_req && (!fifo_full || pop);
    ovf_evt = push_req && fifo_full && !pop;

    if (accept) begin
      last_addr_d = ld_addr;
      last_data_d = ld_data;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Drain FSM: every popped entry becomes exactly one strobe cycle
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          ram_addr_d = head.addr;
          ram_din_d  = head.data;
          ram_we_d   = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (pop) begin
          ram_addr_d = head.addr;
          ram_din_d  = head.data;
          ram_we_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Same-cycle events take priority over the clear
    if (ovf_evt)        overflow_d = 1'b1;
    else if (clr_flags) overflow_d = 1'b0;

    if (drop_evt) begin
      if (clr_flags)                drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_flags) begin
      drop_cnt_d = 8'd0;
    end

    cpu_hold_d = (count_d >= CW'(HOLD_LEVEL));
    busy_d     = ld_wr || (count_d != CW'(0)) || ram_we_d;
  end

  // State and output registers
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prev_wr_q   <= 1'b0;
      last_addr_q <= 16'h0000;
      last_data_q <= 8'h00;
      ram_addr_q  <= 16'h0000;
      ram_din_q   <= 8'h00;
      ram_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prev_wr_q   <= prev_wr_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // FIFO write port
  always_ff @(posedge I_CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: ld_addr, data: ld_data};
  end

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_vz_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_vz_ram_writer
// Self-checking bench for vz_ram_writer: a constant vector table, hand-written
// corner sequences and a randomized run, all compared against a queue-based
// reference model.
// ---------------------------------------------------------------------------
module tb_vz_ram_writer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned HOLD  = 6;
  localparam logic [15:0] LO    = 16'h7800;
  localparam logic [15:0] HI    = 16'hF7FF;

  logic        I_CLK = 1'b0;
  logic        I_RST_N;
  logic        ld_wr;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        clr_flags;
  logic        cpu_slot;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        cpu_hold;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_cnt;

  vz_ram_writer #(
    .DEPTH(DEPTH), .RAM_LO(LO), .RAM_HI(HI), .HOLD_LEVEL(HOLD)
  ) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .clr_flags(clr_flags), .cpu_slot(cpu_slot),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 I_CLK = ~I_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  logic [23:0] mq[$];
  logic        m_prev;
  logic [15:0] m_laddr;
  logic [7:0]  m_ldata;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_din;
  logic        m_hold;
  logic        m_busy;
  logic        m_ovf;
  logic [7:0]  m_drop;

  // Observed strobes
  logic [23:0] strobes[$];
  int          strobe_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev = 0; m_laddr = 0; m_ldata = 0;
    m_we = 0; m_addr = 0; m_din = 0;
    m_hold = 0; m_busy = 0; m_ovf = 0; m_drop = 0;
  endtask

  // One clock edge of the model, computed from the rules on a plain queue
  task automatic model_step();
    bit acc, inwin, was_full, do_pop, lost;
    acc      = ld_wr && (!m_prev || ld_addr != m_laddr || ld_data != m_ldata);
    inwin    = (ld_addr >= LO) && (ld_addr <= HI);
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() != 0) && !cpu_slot;
    lost     = 0;
    if (do_pop) begin
      {m_addr, m_din} = mq.pop_front();
      m_we = 1;
    end else begin
      m_we = 0;
    end
    if (acc && inwin) begin
      if (!was_full || do_pop) mq.push_back({ld_addr, ld_data});
      else lost = 1;
    end
    if (acc) begin
      m_laddr = ld_addr;
      m_ldata = ld_data;
    end
    m_prev = ld_wr;
    if (lost) m_ovf = 1;
    else if (clr_flags) m_ovf = 0;
    if (acc && !inwin) begin
      if (clr_flags) m_drop = 1;
      else if (m_drop != 8'hFF) m_drop = m_drop + 1;
    end else if (clr_flags) begin
      m_drop = 0;
    end
    m_hold = (mq.size() >= HOLD);
    m_busy = ld_wr || (mq.size() != 0) || m_we;
  endtask

  task automatic check_all();
    check("ram_we",   32'(ram_we),   32'(m_we));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_din",  32'(ram_din),  32'(m_din));
    check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    check("busy",     32'(busy),     32'(m_busy));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic tick();
    @(posedge I_CLK);
    model_step();
    cyc++;
    #1;
    check_all();
    if (ram_we) begin
      strobes.push_back({ram_addr, ram_din});
      strobe_cyc.push_back(cyc);
    end
  endtask

  task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       input logic clr, input logic slot);
    ld_wr = wr; ld_addr = a; ld_data = d; clr_flags = clr; cpu_slot = slot;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        clr;
    logic        slot;
    logic        we;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic [7:0]  edrop;
    logic        ebusy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Hand-computed vectors from reset: held write, drops, clear, window edges
    tbl[0]  = '{1'b1, 16'h7AE9, 8'h3C, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'd0, 1'b1};
    tbl[1]  = '{1'b1, 16'h7AE9, 8'h3C, 1'b0, 1'b0, 1'b1, 16'h7AE9, 8'h3C, 8'd0, 1'b1};
    tbl[2]  = '{1'b1, 16'h7AE9, 8'h3C, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd0, 1'b1};
    tbl[3]  = '{1'b1, 16'h7AE9, 8'h3C, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd0, 1'b1};
    tbl[4]  = '{1'b1, 16'h7AE9, 8'h3C, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd0, 1'b1};
    tbl[5]  = '{1'b0, 16'h0010, 8'h55, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd0, 1'b0};
    tbl[6]  = '{1'b1, 16'h0010, 8'h55, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd1, 1'b1};
    tbl[7]  = '{1'b1, 16'hF800, 8'h66, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd2, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd1, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd1, 1'b0};
    tbl[11] = '{1'b1, 16'h7800, 8'hA1, 1'b0, 1'b0, 1'b0, 16'h7AE9, 8'h3C, 8'd1, 1'b1};
    tbl[12] = '{1'b1, 16'hF7FF, 8'hA2, 1'b0, 1'b0, 1'b1, 16'h7800, 8'hA1, 8'd1, 1'b1};
    tbl[13] = '{1'b1, 16'h77FF, 8'hA3, 1'b0, 1'b0, 1'b1, 16'hF7FF, 8'hA2, 8'd2, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'hF7FF, 8'hA2, 8'd2, 1'b0};

    // Reset
    drive(0, 16'h0000, 8'h00, 0, 0);
    I_RST_N = 1'b0;
    model_reset();
    repeat (3) @(negedge I_CLK);
    check("rst ram_we",   32'(ram_we),   32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst drop_cnt", 32'(drop_cnt), 32'd0);
    I_RST_N = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].clr, tbl[i].slot);
      tick();
      check($sformatf("vec%0d we", i),   32'(ram_we),   32'(tbl[i].we));
      check($sformatf("vec%0d addr", i), 32'(ram_addr), 32'(tbl[i].ea));
      check($sformatf("vec%0d din", i),  32'(ram_din),  32'(tbl[i].ed));
      check($sformatf("vec%0d drop", i), 32'(drop_cnt), 32'(tbl[i].edrop));
      check($sformatf("vec%0d busy", i), 32'(busy),     32'(tbl[i].ebusy));
    end

    // Burst with contention: no strobes during the hold, then 4 back-to-back
    strobes.delete(); strobe_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'h7800 + 16'(i), 8'h10 + 8'(i), 0, (i < 3));
      tick();
    end
    drive(0, 16'h0000, 8'h00, 0, 0);
    repeat (6) tick();
    check("burst count", 32'(strobes.size()), 32'd4);
    if (strobes.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("burst entry%0d", k), 32'(strobes[k]),
              32'({16'h7800 + 16'(k), 8'h10 + 8'(k)}));
        check($sformatf("burst b2b%0d", k), 32'(strobe_cyc[k] - strobe_cyc[0]), 32'(k));
      end
    end

    // Overflow and hold
    drive(0, 16'h0000, 8'h00, 1, 0);
    tick();
    strobes.delete(); strobe_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      drive(1, 16'h7900 + 16'(i), 8'(i), 0, 1);
      tick();
      if (i == 4) check("hold after 5", 32'(cpu_hold), 32'd0);
      if (i == 5) check("hold after 6", 32'(cpu_hold), 32'd1);
      if (i == 7) check("ovf after 8",  32'(overflow), 32'd0);
      if (i == 8) check("ovf after 9",  32'(overflow), 32'd1);
    end
    drive(0, 16'h0000, 8'h00, 0, 0);
    repeat (12) tick();
    check("ovf strobes", 32'(strobes.size()), 32'd8);
    if (strobes.size() == 8)
      check("ovf last", 32'(strobes[7]), 32'({16'h7907, 8'h07}));
    check("ovf sticky", 32'(overflow), 32'd1);

    // Re-accept of an identical pair after ld_wr drops
    drive(0, 16'h0000, 8'h00, 1, 0);
    tick();
    strobes.delete(); strobe_cyc.delete();
    drive(1, 16'h78A4, 8'h12, 0, 0); tick(); tick();
    drive(0, 16'h78A4, 8'h12, 0, 0); tick();
    drive(1, 16'h78A4, 8'h12, 0, 0); tick(); tick();
    drive(0, 16'h0000, 8'h00, 0, 0); repeat (3) tick();
    check("reaccept count", 32'(strobes.size()), 32'd2);

    // Full FIFO with push and pop in the same cycle
    strobes.delete(); strobe_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'h7A00 + 16'(i), 8'h80 + 8'(i), 0, 1);
      tick();
    end
    drive(1, 16'h7A08, 8'h88, 0, 0);
    tick();
    check("full pushpop ovf", 32'(overflow), 32'd0);
    check("full pushpop we",  32'(ram_we),   32'd1);
    drive(0, 16'h0000, 8'h00, 0, 1);
    tick();
    check("full still held", 32'(cpu_hold), 32'd1);
    drive(0, 16'h0000, 8'h00, 0, 0);
    repeat (12) tick();
    check("full strobes", 32'(strobes.size()), 32'd9);
    if (strobes.size() == 9)
      check("full last", 32'(strobes[8]), 32'({16'h7A08, 8'h88}));

    // Reset mid-drain
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'h7B00 + 16'(i), 8'(i), 0, 1);
      tick();
    end
    drive(0, 16'h0000, 8'h00, 0, 0);
    tick();
    check("pre-rst we", 32'(ram_we), 32'd1);
    #2;
    I_RST_N = 1'b0;
    #1;
    model_reset();
    check("mid-rst we",   32'(ram_we),   32'd0);
    check("mid-rst hold", 32'(cpu_hold), 32'd0);
    repeat (2) @(negedge I_CLK);
    I_RST_N = 1'b1;
    strobes.delete(); strobe_cyc.delete();
    repeat (8) tick();
    check("post-rst strobes", 32'(strobes.size()), 32'd0);
    check("post-rst busy",    32'(busy),           32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        wr;
      logic [15:0] a;
      logic [7:0]  d;
      wr = ($urandom_range(0, 9) < 7);
      a  = ld_addr;
      d  = ld_data;
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 4) == 0) a = 16'($urandom);
        else a = 16'h7800 + 16'($urandom_range(0, 3));
        d = 8'($urandom_range(0, 3));
      end
      drive(wr, a, d, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 5));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
